// File: rtl/load_store_unit_if.sv
// Memory-side bus of the load/store unit.
//   master : the LSU (drives request, address, byte enables, write data)
//   slave  : the memory (drives ack and read data)
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata : request, held while mem_req=1
//   mem_ack/mem_rdata                        : response, sampled only while mem_req=1
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns a CPU load/store into one word-aligned memory bus
// transaction with little-endian byte enables, and returns the extended load
// result for one cycle.
//   clk, reset         : clock, asynchronous active-low reset
//   memread, memwrite  : load / store request (both set -> store)
//   size, unsignedld   : 00 byte, 01 half, 1x word; zero-extend when set
//   addr, writedata    : byte address, right-aligned store data
//   readdata           : load result, nonzero only in the DONE cycle
//   stall              : hold the pipeline (request cycle + every BUS cycle)
//   misalign, timeout  : one-cycle error pulses
//   mem                : memory bus (load_store_unit_if.master)
// Optional feature: define LSU_TIMEOUT_EN to abandon a bus cycle after
// TIMEOUT_CYCLES cycles without mem_ack (result 32'hDEADBEEF).
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [1:0]  size,
    input  logic        unsignedld,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        stall,
    output logic        misalign,
    output logic        timeout,
    load_store_unit_if.master mem
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2} state_t;

    state_t      state, state_nxt;
    logic        req, mis, aligned_req;
    logic        start, finish, bus_req, stall_c, mis_c;
    logic        tmo_hit;
    logic [3:0]  be_c;
    logic [31:0] wdata_c, load_ext;

    // Transaction latches: everything the bus and the load extension need
    logic        we_q, uns_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic [1:0]  off_q, size_q;

    assign req = memread | memwrite;

    always_comb begin
        mis = 1'b0;
        if (size == 2'b01)  mis = addr[0];
        else if (size[1])   mis = |addr[1:0];
    end

    assign aligned_req = req & ~mis;

    // Lane placement for stores: narrow data is replicated so the memory can
    // take whichever lanes the byte enables select.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = writedata;
        case (size)
            2'b00: begin
                be_c    = 4'b0001 << addr[1:0];
                wdata_c = {4{writedata[7:0]}};
            end
            2'b01: begin
                be_c    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{writedata[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] tmo_cnt;

    // Counts BUS cycles; held at zero outside BUS so every entry starts fresh.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)            tmo_cnt <= '0;
        else if (state != BUS) tmo_cnt <= '0;
        else                   tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo_hit = (state == BUS) && !mem.mem_ack &&
                     (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (aligned_req) state_nxt = BUS;
            BUS:     if (mem.mem_ack || tmo_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        start   = 1'b0;
        finish  = 1'b0;
        bus_req = 1'b0;
        stall_c = 1'b0;
        mis_c   = 1'b0;
        case (state)
            IDLE: begin
                start   = aligned_req;
                stall_c = aligned_req;
                mis_c   = req & mis;
            end
            BUS: begin
                bus_req = 1'b1;
                stall_c = 1'b1;
                finish  = mem.mem_ack | tmo_hit;
            end
            default: ;
        endcase
    end

    // stall is combinational from the request, so gate it with reset to keep
    // it low while reset is held.
    assign stall        = reset & stall_c;
    assign mem.mem_req  = bus_req;
    assign mem.mem_we   = we_q;
    assign mem.mem_addr = addr_q;
    assign mem.mem_be   = be_q;
    assign mem.mem_wdata = wdata_q;

    // Load lane select and extension, from the latched offset/size
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b = mem.mem_rdata[{off_q, 3'b000} +: 8];
        h = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (size_q)
            2'b00:   load_ext = {{24{b[7] & ~uns_q}}, b};
            2'b01:   load_ext = {{16{h[15] & ~uns_q}}, h};
            default: load_ext = mem.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            off_q    <= '0;
            size_q   <= '0;
            readdata <= '0;
            misalign <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            misalign <= mis_c;
            timeout  <= tmo_hit;
            if (start) begin
                we_q    <= memwrite;
                uns_q   <= unsignedld;
                addr_q  <= {addr[31:2], 2'b00};
                wdata_q <= wdata_c;
                be_q    <= be_c;
                off_q   <= addr[1:0];
                size_q  <= size;
            end
            // readdata is loaded only on the way into DONE, so it is zero
            // everywhere else.
            if (finish) begin
                if (tmo_hit)   readdata <= 32'hDEADBEEF;
                else if (we_q) readdata <= '0;
                else           readdata <= load_ext;
            end else begin
                readdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        memread, memwrite, unsignedld;
    logic [1:0]  size;
    logic [31:0] addr, writedata, readdata;
    logic        stall, misalign, timeout;

    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit_if bus();

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .memread    (memread),
        .memwrite   (memwrite),
        .size       (size),
        .unsignedld (unsignedld),
        .addr       (addr),
        .writedata  (writedata),
        .readdata   (readdata),
        .stall      (stall),
        .misalign   (misalign),
        .timeout    (timeout),
        .mem        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a, wd, rdv;
        int          waits;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wdat, res;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: access width in bytes, little-endian lanes, plain arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int nb, off;
        logic [31:0] mask, lane;
        nb   = (v.sz == 2'd0) ? 1 : (v.sz == 2'd1) ? 2 : 4;
        off  = int'(v.a[1:0]);
        r.mis = (off % nb) != 0;
        r.be  = 4'(((1 << nb) - 1) << off);
        for (int i = 0; i < 4; i++) r.wdat[8*i +: 8] = v.wd[8*(i % nb) +: 8];
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*nb)) - 32'h1);
        lane = (v.rdv >> (8*off)) & mask;
        if (!v.uns && nb < 4 && lane[8*nb-1]) lane = lane | ~mask;
        r.res = v.wr ? 32'h0 : lane;
        return r;
    endfunction

    task automatic access(input string nm, input vec_t v);
        int stalls = 0;
        @(negedge clk);
        memread = v.rd; memwrite = v.wr; size = v.sz; unsignedld = v.uns;
        addr = v.a; writedata = v.wd; bus.mem_ack = 1'b0;
        #1;
        if (v.mis) begin
            chk({nm, ".req_stall"}, stall, 0);
            chk({nm, ".req_memreq"}, bus.mem_req, 0);
            @(negedge clk); memread = 0; memwrite = 0; #1;
            chk({nm, ".misalign"}, misalign, 1);
            chk({nm, ".mis_memreq"}, bus.mem_req, 0);
            chk({nm, ".mis_stall"}, stall, 0);
            chk({nm, ".mis_readdata"}, readdata, 0);
            @(negedge clk); #1;
            chk({nm, ".mis_pulse_end"}, misalign, 0);
            chk({nm, ".mis_memreq2"}, bus.mem_req, 0);
            return;
        end
        chk({nm, ".req_stall"}, stall, 1);
        chk({nm, ".req_memreq"}, bus.mem_req, 0);
        if (stall) stalls++;
        for (int c = 0; c <= v.waits; c++) begin
            @(negedge clk);
            bus.mem_ack   = (c == v.waits);
            bus.mem_rdata = (c == v.waits) ? v.rdv : $urandom;
            #1;
            if (stall) stalls++;
            chk({nm, ".bus_memreq"}, bus.mem_req, 1);
            chk({nm, ".bus_readdata"}, readdata, 0);
            chk({nm, ".bus_addr"}, bus.mem_addr, {v.a[31:2], 2'b00});
            chk({nm, ".bus_be"}, bus.mem_be, v.be);
            chk({nm, ".bus_we"}, bus.mem_we, v.wr);
            if (v.wr) chk({nm, ".bus_wdata"}, bus.mem_wdata, v.wdat);
        end
        // DONE: request still held and a stray ack present; both must be ignored
        @(negedge clk);
        bus.mem_rdata = $urandom;
        #1;
        chk({nm, ".done_stall"}, stall, 0);
        chk({nm, ".done_memreq"}, bus.mem_req, 0);
        chk({nm, ".done_readdata"}, readdata, v.res);
        chk({nm, ".done_timeout"}, timeout, 0);
        chk({nm, ".stall_cycles"}, stalls, v.waits + 2);
        @(negedge clk);
        memread = 0; memwrite = 0;
        #1;
        chk({nm, ".idle_memreq"}, bus.mem_req, 0);
        chk({nm, ".idle_readdata"}, readdata, 0);
        chk({nm, ".idle_stall"}, stall, 0);
        bus.mem_ack = 1'b0;
    endtask

    vec_t vecs[12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t v;
        reset = 1'b0; memread = 1'b1; memwrite = 1'b0; size = 2'b10; unsignedld = 1'b0;
        addr = 32'h100; writedata = 32'h0; bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;

        // rd wr sz uns addr wdata rdata waits mis be wdat result
        vecs[0]  = '{1'b1,1'b0,2'b00,1'b0,32'h10010003,32'h0,32'h80FF7F01,0,1'b0,4'h8,32'h0,32'hFFFFFF80};
        vecs[1]  = '{1'b0,1'b1,2'b01,1'b0,32'h10010002,32'h0000BEEF,32'h0,0,1'b0,4'hC,32'hBEEFBEEF,32'h0};
        vecs[2]  = '{1'b1,1'b0,2'b10,1'b0,32'h10010001,32'h0,32'h0,0,1'b1,4'h0,32'h0,32'h0};
        vecs[3]  = '{1'b1,1'b0,2'b01,1'b1,32'h10010002,32'h0,32'h9ABC1234,3,1'b0,4'hC,32'h0,32'h00009ABC};
        vecs[4]  = '{1'b1,1'b0,2'b10,1'b0,32'h20000000,32'h0,32'h12345678,1,1'b0,4'hF,32'h0,32'h12345678};
        vecs[5]  = '{1'b0,1'b1,2'b00,1'b0,32'h00000005,32'h123456A5,32'h0,0,1'b0,4'h2,32'hA5A5A5A5,32'h0};
        vecs[6]  = '{1'b1,1'b0,2'b01,1'b0,32'h00000010,32'h0,32'h00008001,0,1'b0,4'h3,32'h0,32'hFFFF8001};
        vecs[7]  = '{1'b1,1'b0,2'b00,1'b1,32'h00000022,32'h0,32'h00C30000,2,1'b0,4'h4,32'h0,32'h000000C3};
        vecs[8]  = '{1'b1,1'b1,2'b10,1'b0,32'h00000100,32'hCAFEF00D,32'h55555555,0,1'b0,4'hF,32'hCAFEF00D,32'h0};
        vecs[9]  = '{1'b1,1'b0,2'b11,1'b0,32'h00000040,32'h0,32'hA5A50000,0,1'b0,4'hF,32'h0,32'hA5A50000};
        vecs[10] = '{1'b0,1'b1,2'b01,1'b0,32'h00000003,32'h1234,32'h0,0,1'b1,4'h0,32'h0,32'h0};
        vecs[11] = '{1'b1,1'b0,2'b00,1'b0,32'h00000001,32'h0,32'h00007F00,0,1'b0,4'h2,32'h0,32'h0000007F};

        // Reset state, with a request present to show stall is held low
        repeat (2) @(negedge clk);
        #1;
        chk("rst.readdata", readdata, 0);
        chk("rst.stall", stall, 0);
        chk("rst.misalign", misalign, 0);
        chk("rst.timeout", timeout, 0);
        chk("rst.mem_req", bus.mem_req, 0);
        chk("rst.mem_we", bus.mem_we, 0);
        chk("rst.mem_addr", bus.mem_addr, 0);
        chk("rst.mem_be", bus.mem_be, 0);
        chk("rst.mem_wdata", bus.mem_wdata, 0);
        @(negedge clk); memread = 1'b0; reset = 1'b1;

        for (int i = 0; i < 12; i++) access($sformatf("vec%0d", i), vecs[i]);

        // Randomized accesses against the reference model
        for (int i = 0; i < 60; i++) begin
            int op;
            op = $urandom_range(0, 2);
            v.rd  = (op != 1);
            v.wr  = (op != 0);
            v.sz  = 2'($urandom_range(0, 3));
            v.uns = 1'($urandom_range(0, 1));
            v.a   = $urandom;
            if ($urandom_range(0, 3) != 0) v.a[1:0] = (v.sz == 2'd0) ? v.a[1:0] :
                                                       (v.sz == 2'd1) ? {v.a[1], 1'b0} : 2'b00;
            v.wd  = $urandom;
            v.rdv = $urandom;
`ifdef LSU_TIMEOUT_EN
            v.waits = $urandom_range(0, 3);
`else
            v.waits = $urandom_range(0, 6);
`endif
            access($sformatf("rnd%0d", i), model(v));
        end

        // Reset asserted in the second BUS cycle of a store, then a late ack
        @(negedge clk);
        memwrite = 1'b1; memread = 1'b0; size = 2'b10; addr = 32'h300; writedata = 32'h11223344;
        #1 chk("mid.req_stall", stall, 1);
        @(negedge clk); #1;
        chk("mid.bus1_memreq", bus.mem_req, 1);
        chk("mid.bus1_we", bus.mem_we, 1);
        @(negedge clk); reset = 1'b0; #1;
        chk("mid.rst_memreq", bus.mem_req, 0);
        chk("mid.rst_stall", stall, 0);
        chk("mid.rst_we", bus.mem_we, 0);
        chk("mid.rst_addr", bus.mem_addr, 0);
        chk("mid.rst_be", bus.mem_be, 0);
        chk("mid.rst_wdata", bus.mem_wdata, 0);
        chk("mid.rst_readdata", readdata, 0);
        @(negedge clk);
        memwrite = 1'b0; reset = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
        #1;
        chk("mid.late_memreq", bus.mem_req, 0);
        chk("mid.late_stall", stall, 0);
        @(negedge clk); #1;
        chk("mid.late_readdata", readdata, 0);
        chk("mid.late_memreq2", bus.mem_req, 0);
        bus.mem_ack = 1'b0;

`ifdef LSU_TIMEOUT_EN
        // No ack: four BUS cycles, then DONE with the timeout marker
        @(negedge clk);
        memread = 1'b1; size = 2'b10; addr = 32'h400; unsignedld = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            chk("tmo.bus_memreq", bus.mem_req, 1);
            chk("tmo.bus_timeout", timeout, 0);
        end
        @(negedge clk); #1;
        chk("tmo.pulse", timeout, 1);
        chk("tmo.readdata", readdata, 32'hDEADBEEF);
        chk("tmo.memreq", bus.mem_req, 0);
        chk("tmo.stall", stall, 0);
        @(negedge clk); memread = 1'b0; #1;
        chk("tmo.pulse_end", timeout, 0);
        chk("tmo.idle_readdata", readdata, 0);
        chk("tmo.idle_memreq", bus.mem_req, 0);
`else
        // Without the timeout feature a slow memory is simply waited for
        v = '{1'b1,1'b0,2'b10,1'b0,32'h00000500,32'h0,32'h0BADF00D,12,1'b0,4'hF,32'h0,32'h0BADF00D};
        access("longwait", v);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
